// File: rtl/pc_stack_unit.sv
// Program counter with a small LIFO return-address stack.
// Supports increment, absolute jump, PC-relative branch, call and return, with
// sticky overflow/underflow flags. One operation per enabled cycle, selected
// by fixed priority: ret > call > jump > branch > increment.
module pc_stack_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         en,
    input  logic                         jump,
    input  logic [ADDR_W-1:0]            jaddr,
    input  logic                         branch,
    input  logic [ADDR_W-1:0]            boffset,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            pc_value,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    // Modulo-2^ADDR_W add of a two's-complement offset. Offset and pc share a
    // width, so sign extension collapses to a plain wrapping add.
    function automatic logic [ADDR_W-1:0] pc_offset(
        input logic        [ADDR_W-1:0] base,
        input logic signed [ADDR_W-1:0] off
    );
        return base + $unsigned(off);
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // Return-address storage; contents are never reset and only read below sp.
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic signed [ADDR_W-1:0] boff_s;
    logic [ADDR_W-1:0]        pc_inc;
    logic                     full, empty;
    logic                     push;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         rd_idx;

    assign boff_s = boffset;
    assign pc_inc = pc_q + ADDR_W'(1);
    assign full   = (sp_q == SP_FULL);
    assign empty  = (sp_q == '0);
    assign wr_idx = IDX_W'(sp_q);
    assign rd_idx = IDX_W'(sp_q - SP_W'(1));

    // Next-state selection: prioritised operation plus sticky error update.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        push  = 1'b0;
        ovf_d = err_clr ? 1'b0 : ovf_q;
        unf_d = err_clr ? 1'b0 : unf_q;

        if (en) begin
            if (ret) begin
                if (!empty) begin
                    pc_d = stack_q[rd_idx];
                    sp_d = sp_q - SP_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (call) begin
                if (!full) begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                    pc_d = jaddr;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (jump) begin
                pc_d = jaddr;
            end else if (branch) begin
                pc_d = pc_offset(pc_q, boff_s);
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pc_q  <= RESET_ADDR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack write port: return address of the call lands at the current top.
    always_ff @(posedge clk) begin
        if (push && !areset) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign pc_value    = pc_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (ADDR_W=8, DEPTH=4, RESET_ADDR=0).
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       en = 1'b0;
    logic       jump = 1'b0;
    logic [7:0] jaddr = 8'h00;
    logic       branch = 1'b0;
    logic [7:0] boffset = 8'h00;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] pc_value;
    logic [2:0] sp;
    logic       stack_full, stack_empty, ovf_err, unf_err;

    int n_vec = 0;
    int n_bad = 0;

    pc_stack_unit #(.ADDR_W(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .areset(areset), .en(en), .jump(jump), .jaddr(jaddr),
        .branch(branch), .boffset(boffset), .call(call), .ret(ret),
        .err_clr(err_clr), .pc_value(pc_value), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests and let the next rising edge take them.
    task automatic apply(input logic e, input logic j, input logic [7:0] ja,
                         input logic b, input logic [7:0] bo,
                         input logic c, input logic r, input logic ec);
        en = e; jump = j; jaddr = ja; branch = b; boffset = bo;
        call = c; ret = r; err_clr = ec;
        tick();
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc, input logic [2:0] s,
                               input logic ov, input logic un);
        check_val({tag, ".pc"}, 32'(pc_value), 32'(pc));
        check_val({tag, ".sp"}, 32'(sp), 32'(s));
        check_val({tag, ".full"}, 32'(stack_full), 32'(s == 3'd4));
        check_val({tag, ".empty"}, 32'(stack_empty), 32'(s == 3'd0));
        check_val({tag, ".ovf"}, 32'(ovf_err), 32'(ov));
        check_val({tag, ".unf"}, 32'(unf_err), 32'(un));
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 areset = 1'b1;
        #1 check_state("rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #10 areset = 1'b0;
        tick();
        check_state("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);

        // Increment with a one-cycle freeze
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("inc1", 32'(pc_value), 32'h01);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("inc2", 32'(pc_value), 32'h02);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("inc3", 32'(pc_value), 32'h03);
        apply(0, 1, 8'h77, 0, 8'h00, 1, 0, 0); check_state("freeze", 8'h03, 3'd0, 1'b0, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("resume", 32'(pc_value), 32'h04);

        // Wrap-around and negative branch
        apply(1, 1, 8'hFE, 0, 8'h00, 0, 0, 0); check_val("jmp_fe", 32'(pc_value), 32'hFE);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("wrap_ff", 32'(pc_value), 32'hFF);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("wrap_00", 32'(pc_value), 32'h00);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 0, 0); check_val("wrap_01", 32'(pc_value), 32'h01);
        apply(1, 1, 8'h10, 0, 8'h00, 0, 0, 0); check_val("jmp_10", 32'(pc_value), 32'h10);
        apply(1, 0, 8'h00, 1, 8'hFC, 0, 0, 0); check_val("br_neg", 32'(pc_value), 32'h0C);
        apply(1, 0, 8'h00, 1, 8'h7F, 0, 0, 0); check_val("br_pos", 32'(pc_value), 32'h8B);
        apply(1, 1, 8'h20, 1, 8'h04, 0, 0, 0); check_val("jmp_over_br", 32'(pc_value), 32'h20);

        // Call then immediate return
        apply(1, 1, 8'h05, 0, 8'h00, 0, 0, 0); check_val("jmp_05", 32'(pc_value), 32'h05);
        apply(1, 0, 8'h40, 0, 8'h00, 1, 0, 0); check_state("call40", 8'h40, 3'd1, 1'b0, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("ret06", 8'h06, 3'd0, 1'b0, 1'b0);

        // Fill the stack, overflow, drain in reverse
        apply(1, 0, 8'h10, 0, 8'h00, 1, 0, 0); check_state("callA", 8'h10, 3'd1, 1'b0, 1'b0);
        apply(1, 1, 8'h20, 1, 8'h00, 1, 0, 0); check_state("callB", 8'h20, 3'd2, 1'b0, 1'b0);
        apply(1, 0, 8'h30, 0, 8'h00, 1, 0, 0); check_state("callC", 8'h30, 3'd3, 1'b0, 1'b0);
        apply(1, 0, 8'h40, 0, 8'h00, 1, 0, 0); check_state("callD", 8'h40, 3'd4, 1'b0, 1'b0);
        apply(1, 0, 8'h50, 0, 8'h00, 1, 0, 0); check_state("call_ovf", 8'h40, 3'd4, 1'b1, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("retD", 8'h31, 3'd3, 1'b1, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("retC", 8'h21, 3'd2, 1'b1, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("retB", 8'h11, 3'd1, 1'b1, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("retA", 8'h07, 3'd0, 1'b1, 1'b0);
        apply(0, 0, 8'h00, 0, 8'h00, 0, 0, 1); check_state("clr_ovf", 8'h07, 3'd0, 1'b0, 1'b0);

        // Underflow, clear, priority at empty stack
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("ret_unf", 8'h07, 3'd0, 1'b0, 1'b1);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 1); check_state("set_wins", 8'h07, 3'd0, 1'b0, 1'b1);
        apply(0, 0, 8'h00, 0, 8'h00, 0, 0, 1); check_state("clr_unf", 8'h07, 3'd0, 1'b0, 1'b0);
        apply(1, 1, 8'h99, 0, 8'h00, 1, 1, 0); check_state("ret_wins", 8'h07, 3'd0, 1'b0, 1'b1);
        apply(0, 0, 8'h00, 0, 8'h00, 0, 0, 1); check_state("clr2", 8'h07, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset mid call sequence
        apply(1, 1, 8'h88, 1, 8'h01, 1, 0, 0); check_state("call80", 8'h88, 3'd1, 1'b0, 1'b0);
        apply(1, 0, 8'h90, 0, 8'h00, 1, 0, 0); check_state("call90", 8'h90, 3'd2, 1'b0, 1'b0);
        #3 areset = 1'b1;
        #1 check_state("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_state("rst_override", 8'h00, 3'd0, 1'b0, 1'b0);
        #3 areset = 1'b0;
        jaddr = 8'hA0;
        tick();
        check_state("first_op", 8'hA0, 3'd1, 1'b0, 1'b0);
        apply(1, 0, 8'h00, 0, 8'h00, 0, 1, 0); check_state("ret_after_rst", 8'h01, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, program counter and address width in bits (legal range 4..16).
REQ-002 Parameter: DEPTH, default 4, return-stack depth in entries (legal range 2..16).
REQ-003 Parameter: RESET_ADDR, default 0, pc_value loaded on reset (ADDR_W bits).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: areset  input  1  reset, asynchronous, active-high.
REQ-006 Port: en  input  1  advance enable; 0 freezes pc and stack.
REQ-007 Port: jump  input  1  absolute jump request.
REQ-008 Port: jaddr  input  ADDR_W  target for jump and call.
REQ-009 Port: branch  input  1  PC-relative branch request.
REQ-010 Port: boffset  input  ADDR_W  two's-complement branch offset.
REQ-011 Port: call  input  1  push return address, then go to jaddr.
REQ-012 Port: ret  input  1  pop return address into pc.
REQ-013 Port: err_clr  input  1  clears sticky error flags.
REQ-014 Port: pc_value  output  ADDR_W  current program counter (registered).
REQ-015 Port: sp  output  clog2(DEPTH+1)  number of valid stack entries.
REQ-016 Port: stack_full  output  1  high when sp == DEPTH.
REQ-017 Port: stack_empty  output  1  high when sp == 0.
REQ-018 Port: ovf_err  output  1  sticky: call attempted while full.
REQ-019 Port: unf_err  output  1  sticky: ret attempted while empty.

Function
REQ-020 With en=0, pc_value, stack contents and sp SHALL hold; requests SHALL be ignored; err_clr SHALL still act.
REQ-021 With en=1, exactly one operation SHALL execute per cycle, priority ret > call > jump > branch > increment.
REQ-022 Increment SHALL set pc_value <= pc_value + 1, modulo 2^ADDR_W (wrap from all-ones to 0).
REQ-023 Jump SHALL set pc_value <= jaddr on the next edge (1-cycle latency).
REQ-024 Branch SHALL set pc_value <= pc_value + sign-extended boffset, modulo 2^ADDR_W.
REQ-025 Call with sp < DEPTH SHALL write pc_value + 1 (modulo 2^ADDR_W) to entry sp, increment sp, and set pc_value <= jaddr, all in the same cycle.
REQ-026 Call with sp == DEPTH SHALL leave pc_value, stack and sp unchanged and set ovf_err.
REQ-027 Ret with sp > 0 SHALL set pc_value <= entry sp-1 and decrement sp in the same cycle.
REQ-028 Ret with sp == 0 SHALL leave pc_value and sp unchanged and set unf_err.
REQ-029 A lower-priority request asserted together with a higher-priority one SHALL be dropped, not deferred.
REQ-030 stack_full and stack_empty SHALL be combinational decodes of sp, consistent in the same cycle.
REQ-031 err_clr SHALL clear both flags on the next edge; if a new error event occurs in the same cycle, set SHALL win.
REQ-032 The stack SHALL be LIFO; back-to-back call/ret in consecutive cycles SHALL be supported without bubbles.

Reset
REQ-033 areset=1 SHALL immediately, without a clock edge, force pc_value=RESET_ADDR, sp=0, ovf_err=0, unf_err=0.
REQ-034 Stack entry contents need not be reset; unread entries SHALL never reach pc_value.
REQ-035 Reset asserted mid-operation SHALL override any request in that cycle; first operation SHALL execute on the first rising edge after areset deasserts.

Verification
REQ-036 Reset then en=1 for 3 cycles, en=0 for 1 cycle -> pc_value 0,1,2,3,3 then resumes at 4.
REQ-037 pc_value=8'hFE, increment 3 cycles -> FF, 00, 01; branch boffset=8'hFC from 8'h10 -> 8'h0C.
REQ-038 At pc=8'h05: call jaddr=8'h40 then ret -> pc 8'h40 (sp=1), then 8'h06 (sp=0, stack_empty=1).
REQ-039 DEPTH=4: five calls -> sp=4, stack_full=1 after fourth; fifth call leaves pc unchanged, ovf_err=1; four rets return the addresses in reverse order.
REQ-040 ret at sp=0 -> pc unchanged, unf_err=1; err_clr pulse -> unf_err=0 next cycle; simultaneous ret+jump+call at sp=0 -> ret wins, pc holds, unf_err=1.
REQ-041 areset pulse between clock edges during a call sequence -> pc_value=RESET_ADDR and sp=0 immediately, before the next edge.
